// File: rtl/bsg_mul_iterative_pkg.sv
// ============================================================================
// Module   : bsg_mul_iterative_pkg
// Purpose  : Shared op and state encodings for the multiplier request sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bsg_mul_iterative_pkg;

    typedef enum logic [1:0] {
        eMUL    = 2'd0,
        eMULH   = 2'd1,
        eMULHSU = 2'd2,
        eMULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        eIdle  = 3'd0,
        eIssue = 3'd1,
        eWait  = 3'd2,
        eFix   = 3'd3,
        eDone  = 3'd4
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_mul_result_fixup.sv
// ============================================================================
// Module   : bsg_mul_result_fixup
// Purpose  : Selects the requested product half, or recirculates the held
//            result, and optionally subtracts a width_p-bit correction term.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_mul_result_fixup
    import bsg_mul_iterative_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic                   sel_product_i,
    input  mul_op_e                op_i,
    input  logic [2*width_p-1:0]   product_i,
    input  logic [width_p-1:0]     result_i,
    input  logic                   sub_en_i,
    input  logic [width_p-1:0]     subtrahend_i,
    output logic [width_p-1:0]     result_o
);

    logic [width_p-1:0] base;

    always_comb begin
        base = result_i;
        if (sel_product_i) begin
            base = (op_i == eMUL) ? product_i[width_p-1:0]
                                  : product_i[2*width_p-1:width_p];
        end
        result_o = base - (sub_en_i ? subtrahend_i : '0);
    end

endmodule

`default_nettype wire

// File: rtl/bsg_mul_iterative_sequencer.sv
// ============================================================================
// Module   : bsg_mul_iterative_sequencer
// Purpose  : Accepts RISC-V multiply ops, drives the single-signedness Booth
//            multiplier, fixes up MULHSU and returns the selected half + tag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_mul_iterative_sequencer
    import bsg_mul_iterative_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int tag_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [1:0]             op_i,
    input  logic [width_p-1:0]     opA_i,
    input  logic [width_p-1:0]     opB_i,
    input  logic [tag_width_p-1:0] tag_i,

    output logic                   mul_v_o,
    input  logic                   mul_ready_i,
    output logic [width_p-1:0]     mul_opA_o,
    output logic [width_p-1:0]     mul_opB_o,
    output logic                   mul_signed_o,
    input  logic                   mul_v_i,
    input  logic [2*width_p-1:0]   mul_result_i,
    output logic                   mul_yumi_o,

    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

    seq_state_e               state_q, state_d;
    mul_op_e                  op_q, op_d;
    logic [width_p-1:0]       opa_q, opa_d;
    logic [width_p-1:0]       opb_q, opb_d;
    logic [tag_width_p-1:0]   tag_q, tag_d;
    logic [width_p-1:0]       result_q, result_d;

    logic                     sel_product;
    logic                     sub_en;
    logic [width_p-1:0]       fixup_result;

    bsg_mul_result_fixup #(
        .width_p (width_p)
    ) u_fixup (
        .sel_product_i (sel_product),
        .op_i          (op_q),
        .product_i     (mul_result_i),
        .result_i      (result_q),
        .sub_en_i      (sub_en),
        .subtrahend_i  (opb_q),
        .result_o      (fixup_result)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= eIdle;
            op_q     <= eMUL;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        tag_d        = tag_q;
        result_d     = result_q;
        ready_o      = 1'b0;
        mul_v_o      = 1'b0;
        mul_signed_o = 1'b0;
        mul_yumi_o   = 1'b0;
        v_o          = 1'b0;
        sel_product  = 1'b0;
        sub_en       = 1'b0;

        unique case (state_q)
            eIdle: begin
                ready_o    = 1'b1;
                // Drain any result orphaned by a reset mid-operation.
                mul_yumi_o = mul_v_i;
                if (v_i) begin
                    op_d    = mul_op_e'(op_i);
                    opa_d   = opA_i;
                    opb_d   = opB_i;
                    tag_d   = tag_i;
                    state_d = eIssue;
                end
            end
            eIssue: begin
                mul_v_o      = 1'b1;
                mul_signed_o = (op_q == eMULH);
                if (mul_ready_i) begin
                    state_d = eWait;
                end
            end
            eWait: begin
                mul_yumi_o  = mul_v_i;
                sel_product = 1'b1;
                if (mul_v_i) begin
                    result_d = fixup_result;
                    // Unsigned hi(A*B) minus B when A is negative gives hi(sA*uB).
                    state_d  = ((op_q == eMULHSU) && opa_q[width_p-1]) ? eFix : eDone;
                end
            end
            eFix: begin
                sub_en   = 1'b1;
                result_d = fixup_result;
                state_d  = eDone;
            end
            eDone: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = eIdle;
                end
            end
            default: begin
                state_d = eIdle;
            end
        endcase
    end

    assign mul_opA_o = opa_q;
    assign mul_opB_o = opb_q;
    assign data_o    = result_q;
    assign tag_o     = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_mul_iterative_sequencer.sv
// ============================================================================
// Module   : tb_bsg_mul_iterative_sequencer
// Purpose  : Self-checking bench with a behavioural multiplier and reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_mul_iterative_sequencer;

    localparam int W  = 64;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic            v_i = 1'b0;
    logic            ready_o;
    logic [1:0]      op_i = '0;
    logic [W-1:0]    opA_i = '0;
    logic [W-1:0]    opB_i = '0;
    logic [TW-1:0]   tag_i = '0;
    logic            mul_v_o;
    logic            mul_ready_i = 1'b0;
    logic [W-1:0]    mul_opA_o;
    logic [W-1:0]    mul_opB_o;
    logic            mul_signed_o;
    logic            mul_v_i = 1'b0;
    logic [2*W-1:0]  mul_result_i = '0;
    logic            mul_yumi_o;
    logic            v_o;
    logic [W-1:0]    data_o;
    logic [TW-1:0]   tag_o;
    logic            yumi_i = 1'b0;

    always #5 clk = ~clk;

    bsg_mul_iterative_sequencer #(
        .width_p     (W),
        .tag_width_p (TW)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .opA_i        (opA_i),
        .opB_i        (opB_i),
        .tag_i        (tag_i),
        .mul_v_o      (mul_v_o),
        .mul_ready_i  (mul_ready_i),
        .mul_opA_o    (mul_opA_o),
        .mul_opB_o    (mul_opB_o),
        .mul_signed_o (mul_signed_o),
        .mul_v_i      (mul_v_i),
        .mul_result_i (mul_result_i),
        .mul_yumi_o   (mul_yumi_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .tag_o        (tag_o),
        .yumi_i       (yumi_i)
    );

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  data;
    } txn_t;

    txn_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Multiplier model and scoreboard state
    bit             busy, mv, issued, res_got, seen_v;
    int             cnt, cyc, deliver, res_cyc, last_lat;
    logic [2*W-1:0] mprod;
    int             ready_mode, yumi_mode, lat_fix;
    bit             req_pend, req_rand, rand_v;
    logic [1:0]     r_op;
    logic [W-1:0]   r_a, r_b;
    logic [TW-1:0]  r_tag;
    logic [W-1:0]   last_data;
    logic [TW-1:0]  last_tag;
    logic           last_signed;
    int             accepts, delivered;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference from the op definitions: signed/unsigned widening product.
    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] sa, za, sb, zb, p;
        sa = {{W{a[W-1]}}, a};
        za = {{W{1'b0}}, a};
        sb = {{W{b[W-1]}}, b};
        zb = {{W{1'b0}}, b};
        case (op)
            2'd0:    begin p = za * zb; return p[W-1:0]; end
            2'd1:    p = sa * sb;
            2'd2:    p = sa * zb;
            default: p = za * zb;
        endcase
        return p[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom % 4)
            0:       return {$urandom, $urandom};
            1:       return ONES;
            2:       return {1'b1, 31'($urandom), $urandom};
            default: return W'($urandom % 16);
        endcase
    endfunction

    task automatic new_rand_req();
        r_op  = 2'($urandom % 4);
        r_a   = rand_operand();
        r_b   = rand_operand();
        r_tag = TW'($urandom);
    endtask

    task automatic set_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] tag);
        r_op = op; r_a = a; r_b = b; r_tag = tag;
        req_pend = 1'b1;
        req_rand = 1'b0;
        rand_v   = 1'b0;
    endtask

    function automatic bit pick(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'b0;
        return ($urandom % 2) == 1;
    endfunction

    task automatic drive();
        v_i          = req_pend && (rand_v ? (($urandom % 2) == 1) : 1'b1);
        op_i         = r_op;
        opA_i        = r_a;
        opB_i        = r_b;
        tag_i        = r_tag;
        mul_v_i      = mv;
        mul_result_i = mprod;
        mul_ready_i  = !busy && !mv && pick(ready_mode);
        yumi_i       = v_o && pick(yumi_mode);
    endtask

    task automatic compare();
        bit ne, vexp;
        ne   = exp_q.size() != 0;
        vexp = ne && res_got && (cyc >= deliver);
        chk("ready_o", ready_o, !ne);
        chk("mul_v_o", mul_v_o, ne && !issued);
        chk("mul_yumi_o", mul_yumi_o, mv && (!ne || (issued && !res_got)));
        chk("v_o", v_o, vexp);
        chk("data_o_known", $isunknown({data_o, tag_o}), 1'b0);
        if (ne && !issued) begin
            chk("mul_opA_o", mul_opA_o, exp_q[0].a);
            chk("mul_opB_o", mul_opB_o, exp_q[0].b);
            chk("mul_signed_o", mul_signed_o, exp_q[0].op == 2'd1);
        end
        if (vexp) begin
            chk("data_o", data_o, exp_q[0].data);
            chk("tag_o", tag_o, exp_q[0].tag);
            if (!seen_v) begin
                seen_v   = 1'b1;
                last_lat = cyc - res_cyc;
            end
        end
    endtask

    // One clock: resolve handshakes for the coming edge, advance, drive, check.
    task automatic tick();
        bit f_out, f_req, f_iss, f_res;
        logic [2*W-1:0] ea, eb;
        f_out = v_o && yumi_i;
        f_req = v_i && ready_o;
        f_iss = mul_v_o && mul_ready_i;
        f_res = mul_v_i && mul_yumi_o;
        if (f_res) begin
            mv = 1'b0;
            if (exp_q.size() != 0 && issued && !res_got) begin
                res_got = 1'b1;
                res_cyc = cyc;
                deliver = cyc + 1 + (((exp_q[0].op == 2'd2) && exp_q[0].a[W-1]) ? 1 : 0);
            end
        end
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin busy = 1'b0; mv = 1'b1; end
        end
        if (f_iss) begin
            ea = mul_signed_o ? {{W{mul_opA_o[W-1]}}, mul_opA_o} : {{W{1'b0}}, mul_opA_o};
            eb = mul_signed_o ? {{W{mul_opB_o[W-1]}}, mul_opB_o} : {{W{1'b0}}, mul_opB_o};
            mprod       = ea * eb;
            busy        = 1'b1;
            cnt         = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
            issued      = 1'b1;
            last_signed = mul_signed_o;
        end
        if (f_out) begin
            last_data = data_o;
            last_tag  = tag_o;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            issued = 1'b0; res_got = 1'b0; seen_v = 1'b0;
            delivered++;
        end
        if (f_req) begin
            exp_q.push_back('{op: r_op, a: r_a, b: r_b, tag: r_tag,
                              data: ref_result(r_op, r_a, r_b)});
            accepts++;
            issued = 1'b0; res_got = 1'b0; seen_v = 1'b0;
            if (req_rand) new_rand_req();
            else          req_pend = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive();
        #1;
        compare();
    endtask

    task automatic do_reset(input bit orphan);
        reset_n_i = 1'b0;
        mv = 1'b0; busy = 1'b0; mul_v_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
        req_pend = 1'b0; issued = 1'b0; res_got = 1'b0; seen_v = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_ready_o", ready_o, 1'b1);
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_mul_v_o", mul_v_o, 1'b0);
        chk("rst_mul_yumi_o", mul_yumi_o, 1'b0);
        chk("rst_mul_signed_o", mul_signed_o, 1'b0);
        chk("rst_data_o", data_o, '0);
        chk("rst_tag_o", tag_o, '0);
        chk("rst_mul_opA_o", mul_opA_o, '0);
        chk("rst_mul_opB_o", mul_opB_o, '0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset_n_i = 1'b1;
        if (orphan) begin
            mv    = 1'b1;
            mprod = {$urandom, $urandom, $urandom, $urandom};
        end
        drive();
        #1;
        compare();
    endtask

    task automatic run_until_done(input string name, input int limit);
        int n = 0;
        while ((req_pend || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= limit) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, limit);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag);
        ready_mode = 2; yumi_mode = 2;
        set_req(op, a, b, tag);
        run_until_done(name, 200);
    endtask

    initial begin
        int n;
        int acc0;
        cyc = 0; deliver = 0; res_cyc = 0; last_lat = 0; cnt = 0;
        accepts = 0; delivered = 0; lat_fix = 3;
        ready_mode = 2; yumi_mode = 2;
        r_op = '0; r_a = '0; r_b = '0; r_tag = '0; mprod = '0;
        last_data = '0; last_tag = '0; last_signed = 1'b0;
        req_rand = 1'b0; rand_v = 1'b0;

        // Reference pinned against hand-computed values
        chk("ref_mul", ref_result(2'd0, 64'd3, 64'd5), 64'd15);
        chk("ref_mulh", ref_result(2'd1, ONES, ONES), 64'd0);
        chk("ref_mulhu", ref_result(2'd3, ONES, ONES), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ref_mulhsu", ref_result(2'd2, ONES, 64'd2), ONES);

        do_reset(1'b0);

        run_op("t1", 2'd0, 64'd3, 64'd5, 5'd7);
        chk("t1_data", last_data, 64'd15);
        chk("t1_tag", last_tag, 5'd7);
        chk("t1_signed", last_signed, 1'b0);

        run_op("t2a", 2'd1, ONES, ONES, 5'd1);
        chk("t2_mulh", last_data, 64'd0);
        chk("t2_mulh_signed", last_signed, 1'b1);
        run_op("t2b", 2'd3, ONES, ONES, 5'd2);
        chk("t2_mulhu", last_data, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op("t3a", 2'd3, ONES, 64'd2, 5'd3);
        chk("t3_mulhu_lat", last_lat, 1);
        chk("t3_mulhu", last_data, 64'd1);
        run_op("t3b", 2'd2, ONES, 64'd2, 5'd4);
        chk("t3_mulhsu_lat", last_lat, 2);
        chk("t3_mulhsu", last_data, ONES);
        chk("t3_mulhsu_signed", last_signed, 1'b0);

        // Downstream back-pressure with a waiting request
        yumi_mode = 1; ready_mode = 2;
        set_req(2'd3, ONES, 64'd3, 5'd3);
        n = 0;
        while (!v_o && n < 50) begin tick(); n++; end
        chk("t4_reached_done", v_o, 1'b1);
        set_req(2'd0, 64'd6, 64'd7, 5'd9);
        acc0 = accepts;
        repeat (10) tick();
        chk("t4_no_accept", accepts, acc0);
        chk("t4_data_held", data_o, 64'd2);
        chk("t4_tag_held", tag_o, 5'd3);
        chk("t4_ready_low", ready_o, 1'b0);
        yumi_mode = 2;
        yumi_i = 1'b1;
        tick();
        chk("t4_ready_after_yumi", ready_o, 1'b1);
        run_until_done("t4", 200);
        chk("t4_next_data", last_data, 64'd42);
        chk("t4_next_tag", last_tag, 5'd9);

        // Multiplier back-pressure in issue
        ready_mode = 1; yumi_mode = 2;
        set_req(2'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd4);
        repeat (6) tick();
        chk("t5_not_issued", issued, 1'b0);
        ready_mode = 2;
        mul_ready_i = 1'b1;
        tick();
        chk("t5_issue_first_ready", issued, 1'b1);
        chk("t5_signed", last_signed, 1'b1);
        run_until_done("t5", 200);
        chk("t5_data", last_data, ONES);
        chk("t5_tag", last_tag, 5'd4);

        // Reset while waiting on the multiplier, then an orphan result
        lat_fix = 30;
        set_req(2'd0, 64'd1234, 64'd5678, 5'd2);
        n = 0;
        while (!(issued && !res_got) && n < 50) begin tick(); n++; end
        chk("t6_in_wait", issued, 1'b1);
        repeat (3) tick();
        do_reset(1'b1);
        chk("t6_orphan_drain", mul_yumi_o, 1'b1);
        chk("t6_no_v_o", v_o, 1'b0);
        repeat (3) tick();
        chk("t6_orphan_gone", mul_v_i, 1'b0);
        lat_fix = 0;
        run_op("t6", 2'd3, 64'h10, 64'h10, 5'd6);
        chk("t6_data", last_data, 64'd0);
        chk("t6_tag", last_tag, 5'd6);

        // Randomised traffic with back-pressure on both sides
        ready_mode = 0; yumi_mode = 0; lat_fix = 0;
        acc0 = delivered;
        new_rand_req();
        req_pend = 1'b1; req_rand = 1'b1; rand_v = 1'b1;
        repeat (3000) tick();
        req_rand = 1'b0;
        run_until_done("rand", 500);
        chk("rand_progress", (delivered - acc0) > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
